// File: rtl/pipe_mem_arbiter_pkg.sv
// Shared types for the IF/MEM unified-memory arbiter: FSM states, grant
// encoding and the starvation counter width.
package pipe_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } grant_e;

    localparam int STARVE_W = 4;

endpackage

// File: rtl/pipe_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and the MEM stage.
// Data side has priority; a saturating starvation counter forces fetch progress.
module pipe_mem_arbiter
    import pipe_mem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_kill,
    output logic [31:0]   if_rdata,
    output logic          if_valid,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [31:0]   dm_wdata,
    input  logic [3:0]    dm_wstrb,
    output logic [31:0]   dm_rdata,
    output logic          dm_valid,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wstrb,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    arb_state_e           state;
    arb_state_e           state_nxt;
    grant_e               grant;
    logic [STARVE_W-1:0]  starve_cnt;
    logic                 kill_pend;
    logic                 ack_i;
    logic                 ack_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = GNT_NONE;
        case (state)
            IDLE: begin
                if (dm_req && (!if_req || (starve_cnt < STARVE_LIM))) begin
                    grant     = GNT_D;
                    state_nxt = BUSY_D;
                end else if (if_req) begin
                    grant     = GNT_I;
                    state_nxt = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // mem_req comes straight from state so an async reset drops it at once.
    always_comb begin
        mem_req = (state == BUSY_I) || (state == BUSY_D);
        ack_i   = (state == BUSY_I) && mem_ack;
        ack_d   = (state == BUSY_D) && mem_ack;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            if_valid   <= 1'b0;
            dm_valid   <= 1'b0;
            kill_pend  <= 1'b0;
            starve_cnt <= '0;
        end else begin
            if (grant == GNT_D) begin
                mem_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
                mem_wstrb <= dm_wstrb;
            end else if (grant == GNT_I) begin
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wstrb <= 4'b0000;
            end

            if (state == IDLE) begin
                if (grant == GNT_D && if_req) begin
                    if (starve_cnt < STARVE_LIM) begin
                        starve_cnt <= starve_cnt + STARVE_W'(1);
                    end
                end else if (grant == GNT_I || !if_req) begin
                    starve_cnt <= '0;
                end
            end

            // A kill landing on the completing edge still suppresses the pulse.
            if (ack_i) begin
                kill_pend <= 1'b0;
            end else if (state == BUSY_I && if_kill) begin
                kill_pend <= 1'b1;
            end

            if (ack_i) begin
                if_rdata <= mem_rdata;
            end
            if (ack_d && !mem_we) begin
                dm_rdata <= mem_rdata;
            end

            if_valid <= ack_i && !kill_pend && !if_kill;
            dm_valid <= ack_d;
        end
    end

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed bench for pipe_mem_arbiter: fetch, priority, starvation, write,
// kill and mid-transaction reset, with hand-computed expectations.
module tb_pipe_mem_arbiter;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_kill;
    logic [31:0]   if_rdata;
    logic          if_valid;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_wdata;
    logic [3:0]    dm_wstrb;
    logic [31:0]   dm_rdata;
    logic          dm_valid;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
    logic          man_ack;
    logic          auto_ack;

    int total = 0;
    int bad   = 0;

    assign mem_ack = auto_ack ? mem_req : man_ack;

    always #5 clk = ~clk;

    pipe_mem_arbiter #(.AW(AW), .STARVE_MAX(2)) dut (
        .clk(clk), .rstn(rstn),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [5:0] order;
        int         ng;

        rstn = 1'b0; if_req = 1'b0; if_addr = '0; if_kill = 1'b0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0;
        man_ack = 1'b0; auto_ack = 1'b0; mem_rdata = '0;
        tick(); tick();
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_if_valid", 32'(if_valid), 0);
        chk("rst_dm_valid", 32'(dm_valid), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);

        // Test 1: single fetch, ack two cycles after mem_req
        rstn = 1'b1; if_req = 1'b1; if_addr = 32'h0000_0010;
        tick();
        chk("t1_mem_req", 32'(mem_req), 1);
        chk("t1_mem_addr", mem_addr, 32'h10);
        chk("t1_mem_wstrb", 32'(mem_wstrb), 0);
        chk("t1_mem_we", 32'(mem_we), 0);
        tick();
        chk("t1_wait_req", 32'(mem_req), 1);
        chk("t1_wait_valid", 32'(if_valid), 0);
        man_ack = 1'b1; mem_rdata = 32'h0050_0093;
        tick();
        chk("t1_if_valid", 32'(if_valid), 1);
        chk("t1_if_rdata", if_rdata, 32'h0050_0093);
        chk("t1_req_drop", 32'(mem_req), 0);
        man_ack = 1'b0; if_req = 1'b0;
        tick();
        chk("t1_pulse_once", 32'(if_valid), 0);
        chk("t1_idle", 32'(mem_req), 0);

        // Test 2: simultaneous requests, D first then I
        if_req = 1'b1; if_addr = 32'h40;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
        tick();
        chk("t2_d_grant", mem_addr, 32'h100);
        chk("t2_d_req", 32'(mem_req), 1);
        man_ack = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        chk("t2_dm_valid", 32'(dm_valid), 1);
        chk("t2_dm_rdata", dm_rdata, 32'h1234_5678);
        man_ack = 1'b0; dm_req = 1'b0;
        tick();
        chk("t2_i_grant", mem_addr, 32'h40);
        chk("t2_i_req", 32'(mem_req), 1);
        chk("t2_dm_valid_end", 32'(dm_valid), 0);
        man_ack = 1'b1; mem_rdata = 32'hAAAA_5555;
        tick();
        chk("t2_if_valid", 32'(if_valid), 1);
        chk("t2_if_rdata", if_rdata, 32'hAAAA_5555);
        man_ack = 1'b0; if_req = 1'b0;
        tick();

        // Test 3: starvation with STARVE_MAX=2 and zero-wait memory
        auto_ack = 1'b1; mem_rdata = 32'h3333_3333;
        dm_req = 1'b1; dm_addr = 32'h100; if_req = 1'b1; if_addr = 32'h40;
        order = '0; ng = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (mem_req && ng < 6) begin
                order = {order[4:0], (mem_addr == 32'h100)};
                ng++;
            end
        end
        dm_req = 1'b0; if_req = 1'b0; auto_ack = 1'b0;
        chk("t3_grant_count", 32'(ng), 6);
        chk("t3_order_DDIDDI", 32'(order), 32'b110110);
        tick();

        // Test 4: write, payload stable after grant, dm_rdata untouched
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200;
        dm_wdata = 32'hDEAD_BEEF; dm_wstrb = 4'b0011;
        tick();
        chk("t4_mem_we", 32'(mem_we), 1);
        chk("t4_mem_addr", mem_addr, 32'h200);
        chk("t4_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("t4_mem_wstrb", 32'(mem_wstrb), 32'h3);
        dm_wdata = 32'h0; dm_addr = 32'h999;
        tick();
        chk("t4_wdata_stable", mem_wdata, 32'hDEAD_BEEF);
        chk("t4_addr_stable", mem_addr, 32'h200);
        man_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        chk("t4_dm_valid", 32'(dm_valid), 1);
        chk("t4_dm_rdata_kept", dm_rdata, 32'h3333_3333);
        man_ack = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        tick();

        // Test 5: kill after I grant, pending D granted next
        if_req = 1'b1; if_addr = 32'h80;
        tick();
        chk("t5_i_grant", mem_addr, 32'h80);
        if_kill = 1'b1; dm_req = 1'b1; dm_addr = 32'h100;
        tick();
        if_kill = 1'b0; if_addr = 32'h90;
        tick();
        tick();
        chk("t5_req_held", 32'(mem_req), 1);
        man_ack = 1'b1; mem_rdata = 32'h7777_7777;
        tick();
        chk("t5_no_if_valid", 32'(if_valid), 0);
        chk("t5_req_drop", 32'(mem_req), 0);
        man_ack = 1'b0;
        tick();
        chk("t5_d_next", mem_addr, 32'h100);
        chk("t5_d_req", 32'(mem_req), 1);
        chk("t5_starve_one", 32'(dut.starve_cnt), 1);

        // Test 6: async reset in BUSY_D
        rstn = 1'b0;
        #1;
        chk("t6_mem_req", 32'(mem_req), 0);
        chk("t6_mem_addr", mem_addr, 0);
        chk("t6_if_rdata", if_rdata, 0);
        chk("t6_dm_rdata", dm_rdata, 0);
        dm_req = 1'b0; if_req = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        chk("t6_post_idle", 32'(dut.state), 0);
        chk("t6_post_starve", 32'(dut.starve_cnt), 0);
        chk("t6_post_req", 32'(mem_req), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
